// File: rtl/mmio_timer.sv
// Memory-mapped 32-bit timer with prescaler, compare match, optional auto-reload
// and a level interrupt. Reads are registered and acknowledged one cycle later.
module mmio_timer #(
  parameter logic [31:0] PRESCALE_RST = 32'd11999,
  parameter logic [31:0] COMPARE_RST  = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  addr,
  input  logic [31:0] data_in,
  input  logic [3:0]  sel,
  input  logic        mem_en,
  input  logic        mem_write,
  output logic [31:0] data_out,
  output logic        read_ack,
  output logic        irq
);

  typedef enum logic [2:0] {
    REG_CTRL     = 3'd0,
    REG_PRESCALE = 3'd1,
    REG_COUNT    = 3'd2,
    REG_COMPARE  = 3'd3,
    REG_STATUS   = 3'd4
  } reg_e;

  logic [2:0]  ctrl;
  logic [31:0] prescale;
  logic [31:0] count;
  logic [31:0] compare;
  logic [31:0] pre_cnt;
  logic        match;

  logic [31:0] wmask;
  logic [31:0] rdata;
  logic [2:0]  ctrl_nxt;
  logic        wr, wr_ctrl, wr_pre, wr_count, wr_cmp, wr_status;
  logic        en_rise, tick, hit, rd_accept;

  always_comb begin
    wmask = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      wmask[8*i +: 8] = {8{sel[i]}};
    end
  end

  assign wr        = mem_en & mem_write;
  assign wr_ctrl   = wr & (addr == REG_CTRL);
  assign wr_pre    = wr & (addr == REG_PRESCALE);
  assign wr_count  = wr & (addr == REG_COUNT);
  assign wr_cmp    = wr & (addr == REG_COMPARE);
  assign wr_status = wr & (addr == REG_STATUS);

  assign ctrl_nxt  = wr_ctrl ? ((ctrl & ~wmask[2:0]) | (data_in[2:0] & wmask[2:0])) : ctrl;
  assign en_rise   = ~ctrl[0] & ctrl_nxt[0];
  // Tick and match are judged on pre-edge state so same-edge bus writes never
  // feed back into this cycle's comparison.
  assign tick      = ctrl[0] & (pre_cnt == prescale);
  assign hit       = tick & (count == compare);
  assign rd_accept = mem_en & ~mem_write & ~read_ack;

  always_comb begin
    rdata = '0;
    case (addr)
      REG_CTRL:     rdata = {29'd0, ctrl};
      REG_PRESCALE: rdata = prescale;
      REG_COUNT:    rdata = count;
      REG_COMPARE:  rdata = compare;
      REG_STATUS:   rdata = {31'd0, match};
      default:      rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl     <= '0;
      prescale <= PRESCALE_RST;
      count    <= '0;
      compare  <= COMPARE_RST;
      pre_cnt  <= '0;
      match    <= 1'b0;
      data_out <= '0;
      read_ack <= 1'b0;
    end else begin
      ctrl <= ctrl_nxt;

      if (wr_pre) prescale <= (prescale & ~wmask) | (data_in & wmask);

      if (!ctrl[0] || en_rise || wr_pre) pre_cnt <= '0;
      else if (tick)                     pre_cnt <= '0;
      else                               pre_cnt <= pre_cnt + 32'd1;

      if (wr_count)  count <= (count & ~wmask) | (data_in & wmask);
      else if (tick) count <= (hit && ctrl[1]) ? '0 : count + 32'd1;

      if (wr_cmp) compare <= (compare & ~wmask) | (data_in & wmask);

      if (hit)                                 match <= 1'b1;
      else if (wr_status && sel[0] && data_in[0]) match <= 1'b0;

      read_ack <= rd_accept;
      if (rd_accept) data_out <= rdata;
    end
  end

  assign irq = match & ctrl[2];

endmodule

// File: tb/tb_mmio_timer.sv
// Randomised and directed bench for mmio_timer: a behavioural register model
// predicts read data and irq; a monitor pops the expected reads on read_ack.
module tb_mmio_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  addr;
  logic [31:0] data_in;
  logic [3:0]  sel;
  logic        mem_en;
  logic        mem_write;
  logic [31:0] data_out;
  logic        read_ack;
  logic        irq;

  always #5 clk = ~clk;

  mmio_timer #(.PRESCALE_RST(32'd11999), .COMPARE_RST(32'hFFFFFFFF)) dut (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .sel(sel),
    .mem_en(mem_en), .mem_write(mem_write), .data_out(data_out),
    .read_ack(read_ack), .irq(irq)
  );

  int total = 0;
  int bad   = 0;
  bit mon_on = 0;

  // Model: index 0 CTRL, 1 PRESCALE, 2 COUNT, 3 COMPARE, 4 STATUS
  logic [31:0] m_reg [0:4];
  logic [31:0] m_pcnt;
  logic [31:0] m_dout;
  bit          m_ack;
  logic [31:0] exp_q [$];

  task automatic check(string name, logic [31:0] act, logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, expv, $time);
    end
  endtask

  task automatic timeout_fail(string name);
    total++;
    bad++;
    $display("FAIL %s actual=timeout expected=event t=%0t", name, $time);
  endtask

  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n, logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] reg_val(logic [2:0] a);
    case (a)
      3'd0: return m_reg[0];
      3'd1: return m_reg[1];
      3'd2: return m_reg[2];
      3'd3: return m_reg[3];
      3'd4: return m_reg[4];
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    logic [31:0] old [0:4];
    logic [31:0] v;
    bit tick, hit, rd;
    old = m_reg;
    if (rst) begin
      m_reg  = '{32'd0, 32'd11999, 32'd0, 32'hFFFFFFFF, 32'd0};
      m_pcnt = 0;
      m_dout = 0;
      m_ack  = 0;
    end else begin
      rd   = mem_en && !mem_write && !m_ack;
      tick = old[0][0] && (m_pcnt == old[1]);
      hit  = tick && (old[2] == old[3]);
      if (rd) begin
        v = reg_val(addr);
        exp_q.push_back(v);
        m_dout = v;
      end
      m_ack = rd;
      if (old[0][0]) m_pcnt = tick ? 32'd0 : m_pcnt + 1;
      else           m_pcnt = 0;
      if (tick) m_reg[2] = (hit && old[0][1]) ? 32'd0 : old[2] + 1;
      if (hit)  m_reg[4] = 1;
      if (mem_en && mem_write) begin
        case (addr)
          3'd0: begin
            m_reg[0] = merge(old[0], data_in, sel) & 32'd7;
            if (!old[0][0] && m_reg[0][0]) m_pcnt = 0;
          end
          3'd1: begin m_reg[1] = merge(old[1], data_in, sel); m_pcnt = 0; end
          3'd2: m_reg[2] = merge(old[2], data_in, sel);
          3'd3: m_reg[3] = merge(old[3], data_in, sel);
          3'd4: if (sel[0] && data_in[0] && !hit) m_reg[4] = 0;
          default: ;
        endcase
      end
    end
  endtask

  task automatic drive(bit r, bit en, bit we, logic [2:0] a, logic [31:0] d, logic [3:0] s);
    @(negedge clk);
    rst = r; mem_en = en; mem_write = we; addr = a; data_in = d; sel = s;
    @(posedge clk);
    model_step();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 3'd0, 32'd0, 4'd0);
  endtask

  task automatic wr(logic [2:0] a, logic [31:0] d, logic [3:0] s);
    drive(0, 1, 1, a, d, s);
  endtask

  task automatic rd(logic [2:0] a);
    drive(0, 1, 0, a, 32'd0, 4'd0);
    idle(1);
  endtask

  // Monitor: scoreboard pop on read_ack, plus ack/irq/hold checks each cycle.
  initial begin
    bit prev_ack;
    logic [31:0] e;
    prev_ack = 0;
    wait (mon_on);
    forever begin
      @(negedge clk);
      check("read_ack", {31'd0, read_ack}, {31'd0, m_ack});
      check("irq", {31'd0, irq}, {31'd0, m_reg[4][0] & m_reg[0][2]});
      if (read_ack) begin
        check("ack_back_to_back", {31'd0, prev_ack}, 32'd0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ack actual=%h expected=none", data_out);
        end else begin
          e = exp_q.pop_front();
          check("read_data", data_out, e);
        end
      end else begin
        check("data_hold", data_out, m_dout);
      end
      prev_ack = read_ack;
    end
  end

  task automatic wait_hit_edge(string name);
    int n;
    n = 0;
    while (!(m_reg[0][0] && m_pcnt == m_reg[1] && m_reg[2] == m_reg[3]) && n < 300) begin
      idle(1);
      n++;
    end
    if (n >= 300) timeout_fail(name);
  endtask

  initial begin
    int op;
    logic [2:0] a;
    rst = 1; mem_en = 0; mem_write = 0; addr = 0; data_in = 0; sel = 0;
    drive(1, 0, 0, 3'd0, 32'd0, 4'd0);
    drive(1, 0, 0, 3'd0, 32'd0, 4'd0);
    mon_on = 1;

    // Reset values, then a held read request
    for (int i = 0; i < 5; i++) rd(3'(i));
    for (int i = 0; i < 6; i++) drive(0, 1, 0, 3'd1, 32'd0, 4'd0);
    idle(1);

    // Prescale 3, compare 5, auto-reload with irq
    wr(3'd1, 32'd3, 4'hF);
    wr(3'd3, 32'd5, 4'hF);
    wr(3'd0, 32'd7, 4'hF);
    for (int i = 0; i < 20; i++) rd(3'd2);
    rd(3'd4);

    // W1C drop, then W1C colliding with a new match
    wr(3'd4, 32'd1, 4'h1);
    rd(3'd4);
    wait_hit_edge("wait_match_edge");
    wr(3'd4, 32'd1, 4'h1);
    rd(3'd4);

    // Wrap without reload, irq disabled
    wr(3'd0, 32'd0, 4'hF);
    wr(3'd2, 32'hFFFFFFFE, 4'hF);
    wr(3'd1, 32'd0, 4'hF);
    wr(3'd3, 32'd2, 4'hF);
    wr(3'd4, 32'd1, 4'hF);
    wr(3'd0, 32'd1, 4'hF);
    for (int i = 0; i < 4; i++) rd(3'd2);
    rd(3'd4);

    // Byte enables and unmapped offsets
    wr(3'd0, 32'd0, 4'hF);
    wr(3'd3, 32'hFFFFFFFF, 4'hF);
    wr(3'd3, 32'h12345678, 4'b0101);
    rd(3'd3);
    wr(3'd6, 32'hDEADBEEF, 4'hF);
    for (int i = 0; i < 8; i++) rd(3'(i));

    // Reset on a read accept edge while counting
    wr(3'd1, 32'd0, 4'hF);
    wr(3'd0, 32'd1, 4'hF);
    idle(3);
    drive(1, 1, 0, 3'd2, 32'd0, 4'd0);
    idle(3);
    for (int i = 0; i < 5; i++) rd(3'(i));

    // Random traffic
    wr(3'd1, 32'd1, 4'hF);
    wr(3'd3, 32'd6, 4'hF);
    for (int i = 0; i < 1500; i++) begin
      op = $urandom_range(0, 9);
      a  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 299) == 0) begin
        drive(1, 1, $urandom_range(0, 1) != 0, a, 32'd0, 4'd0);
        wr(3'd1, 32'd1, 4'hF);
        wr(3'd3, 32'd6, 4'hF);
      end else if (op <= 3) begin
        drive(0, 1, 0, a, 32'd0, 4'd0);
      end else if (op <= 6) begin
        idle(1);
      end else begin
        case (a)
          3'd1:    wr(a, 32'($urandom_range(0, 3)), 4'hF);
          3'd2, 3'd3: wr(a, 32'($urandom_range(0, 20)), 4'($urandom_range(0, 15)));
          default: wr(a, $urandom, 4'($urandom_range(0, 15)));
        endcase
      end
    end

    idle(4);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
